// File: rtl/lvds_link_pkg.sv
// Shared definitions for the LVDS serial link: word width, frame delimiter,
// frame length and the transmit framer state encoding.
package lvds_link_pkg;

  localparam int          LVDS_WORD_W     = 32;
  localparam logic [31:0] SYNC_WORD       = 32'h5346444B;
  localparam int          WORDS_PER_FRAME = 8;

  typedef enum logic [1:0] {
    ST_GAP,
    ST_IDLE,
    ST_SYNC,
    ST_DATA
  } lvds_state_e;

endpackage

// File: rtl/lvds_tx_fifo.sv
// Single-clock show-ahead word FIFO buffering payload ahead of the framer.
module lvds_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          lvds_clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Guards keep the pointers coherent even if a caller ignores full/empty.
  assign do_push = push && !full;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge lvds_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge lvds_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/lvds_frame_tx.sv
// LVDS frame transmitter: sync word, WORDS_PER_FRAME payload words MSB-first,
// then an all-zero gap. Frames start only once a whole frame is buffered.
module lvds_frame_tx
  import lvds_link_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_BITS   = 32
) (
  input  logic                   lvds_clk,
  input  logic                   rst_n,
  input  logic [LVDS_WORD_W-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   lvds_data_out,
  output logic                   tx_busy,
  output logic                   frame_done,
  output lvds_state_e            dbg_state
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WCW = $clog2(WORDS_PER_FRAME);
  localparam int GCW = $clog2(GAP_BITS);
  localparam logic [WCW-1:0] LAST_WORD   = WCW'(WORDS_PER_FRAME - 1);
  localparam logic [GCW-1:0] LAST_GAP    = GCW'(GAP_BITS - 1);
  localparam logic [AW:0]    FRAME_WORDS = (AW+1)'(WORDS_PER_FRAME);

  lvds_state_e            state_q, state_d;
  logic [LVDS_WORD_W-1:0] tx_sh_q, tx_sh_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]         word_cnt_q, word_cnt_d;
  logic [GCW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                   frame_done_q, frame_done_d;

  logic                   fifo_push, fifo_pop, fifo_full;
  logic [LVDS_WORD_W-1:0] fifo_dout;
  logic [AW:0]            fifo_count;

  // valid/ready: a word transfers on any edge where s_valid && s_ready;
  // s_ready depends only on FIFO occupancy, never on s_valid.
  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && s_ready;

  lvds_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (LVDS_WORD_W)
  ) u_fifo (
    .lvds_clk (lvds_clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .din      (s_data),
    .dout     (fifo_dout),
    .count    (fifo_count),
    .full     (fifo_full)
  );

  always_comb begin
    state_d      = state_q;
    tx_sh_d      = {tx_sh_q[LVDS_WORD_W-2:0], 1'b0};
    bit_cnt_d    = bit_cnt_q + 5'd1;
    word_cnt_d   = word_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frame_done_d = 1'b0;
    fifo_pop     = 1'b0;
    unique case (state_q)
      ST_GAP: begin
        tx_sh_d   = '0;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q + GCW'(1);
        if (gap_cnt_q == LAST_GAP) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        tx_sh_d   = tx_sh_q;
        bit_cnt_d = bit_cnt_q;
        if (fifo_count >= FRAME_WORDS) begin
          tx_sh_d   = SYNC_WORD;
          bit_cnt_d = '0;
          state_d   = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (bit_cnt_q == 5'd31) begin
          tx_sh_d    = fifo_dout;
          fifo_pop   = 1'b1;
          word_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_cnt_q == 5'd31) begin
          if (word_cnt_q == LAST_WORD) begin
            tx_sh_d      = '0;
            frame_done_d = 1'b1;
            gap_cnt_d    = '0;
            state_d      = ST_GAP;
          end else begin
            tx_sh_d    = fifo_dout;
            fifo_pop   = 1'b1;
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
      default: state_d = ST_GAP;
    endcase
  end

  always_ff @(posedge lvds_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_GAP;
      tx_sh_q      <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_sh_q      <= tx_sh_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lvds_data_out = tx_sh_q[LVDS_WORD_W-1];
  assign tx_busy       = (state_q == ST_SYNC) || (state_q == ST_DATA);
  assign frame_done    = frame_done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_lvds_frame_tx.sv
// Bench for lvds_frame_tx: frame vectors from a table, a serial receiver
// model feeding a word scoreboard, and hand-written timing/reset sequences.
module tb_lvds_frame_tx;
  import lvds_link_pkg::*;

  localparam int WPF = WORDS_PER_FRAME;

  logic        lvds_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic [31:0] s_data   = '0;
  logic        s_valid  = 1'b0;
  logic        s_ready, lvds_data_out, tx_busy, frame_done;
  lvds_state_e dbg_state;

  lvds_frame_tx u_dut (
    .lvds_clk      (lvds_clk),
    .rst_n         (rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .lvds_data_out (lvds_data_out),
    .tx_busy       (tx_busy),
    .frame_done    (frame_done),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 lvds_clk = ~lvds_clk;

  int cyc = 0;
  always @(posedge lvds_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- line monitor / receiver model ----------------
  logic        line_hist [0:65535];
  logic [31:0] rx_q [$];
  int          sync_q [$];
  int          busy_q [$];
  int          fd_q [$];
  logic        rx_hunting = 1'b1;
  logic [31:0] rx_win = '0;
  logic [31:0] rx_sh = '0;
  int          rx_bits = 0;
  int          rx_words = 0;
  logic        prev_busy = 1'b0;

  always @(negedge lvds_clk) begin
    if (cyc < 65536) line_hist[cyc] = lvds_data_out;
    if (!rst_n) begin
      rx_hunting = 1'b1;
      rx_win     = '0;
      rx_bits    = 0;
      rx_words   = 0;
      prev_busy  = 1'b0;
    end else begin
      if (tx_busy && !prev_busy) busy_q.push_back(cyc);
      prev_busy = tx_busy;
      if (frame_done) fd_q.push_back(cyc);
      if (rx_hunting) begin
        rx_win = {rx_win[30:0], lvds_data_out};
        if (rx_win == SYNC_WORD) begin
          rx_hunting = 1'b0;
          sync_q.push_back(cyc);
          rx_bits  = 0;
          rx_words = 0;
        end
      end else begin
        rx_sh   = {rx_sh[30:0], lvds_data_out};
        rx_bits = rx_bits + 1;
        if (rx_bits == 32) begin
          rx_q.push_back(rx_sh);
          rx_bits  = 0;
          rx_words = rx_words + 1;
          if (rx_words == WPF) begin
            rx_hunting = 1'b1;
            rx_win     = '0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / checks ----------------
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int rx_rd    = 0;
  int push_cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [31:0] w);
    int t = 0;
    @(negedge lvds_clk);
    while (!s_ready && t < 2000) begin
      @(negedge lvds_clk);
      t++;
    end
    if (!s_ready) begin
      check("push_ready_timeout", 64'd0, 64'd1);
    end else begin
      s_data  = w;
      s_valid = 1'b1;
      @(posedge lvds_clk);
      #1;
      push_cyc = cyc;
      s_valid  = 1'b0;
      exp_q.push_back(w);
    end
  endtask

  task automatic idle_watch(input string tag, input int n);
    int ones = 0;
    int busy = 0;
    int done = 0;
    repeat (n) begin
      @(negedge lvds_clk);
      if (lvds_data_out) ones++;
      if (tx_busy) busy++;
      if (frame_done) done++;
    end
    check({tag, "_line_ones"}, 64'(ones), 64'd0);
    check({tag, "_busy_cycles"}, 64'(busy + done), 64'd0);
  endtask

  task automatic compare_rx(input string tag, input int n);
    int t = 0;
    while (rx_q.size() < rx_rd + n && t < 1500) begin
      @(negedge lvds_clk);
      t++;
    end
    check({tag, "_rx_words_available"}, 64'(rx_q.size() >= rx_rd + n), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (rx_rd < rx_q.size() && exp_q.size() > 0) begin
        check($sformatf("%s_word%0d", tag, i), 64'(rx_q[rx_rd]), 64'(exp_q.pop_front()));
        rx_rd++;
      end
    end
  endtask

  // Waits for the frame whose events sit at the given queue indices.
  task automatic frame_checks(input string tag, input int fd0, input int b0, input int s0);
    int t = 0;
    while (fd_q.size() <= fd0 && t < 1500) begin
      @(negedge lvds_clk);
      t++;
    end
    check({tag, "_frame_done_seen"}, 64'(fd_q.size() > fd0), 64'd1);
    compare_rx(tag, WPF);
    if (fd_q.size() > fd0 && busy_q.size() > b0 && sync_q.size() > s0) begin
      check({tag, "_busy_len"}, 64'(fd_q[fd0] - busy_q[b0]), 64'd288);
      check({tag, "_sync_at_busy_rise"}, 64'(sync_q[s0] - 31), 64'(busy_q[b0]));
    end
    repeat (40) @(negedge lvds_clk);
    check({tag, "_done_pulses"}, 64'(fd_q.size() - fd0), 64'd1);
    check({tag, "_sync_hits"}, 64'(sync_q.size() - s0), 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string              name;
    logic [WPF-1:0][31:0] w;
  } frame_vec_t;

  frame_vec_t vecs [4];

  initial begin
    int fd0, b0, s0, st1, st2, zeros, n;

    for (int i = 0; i < WPF; i++) begin
      vecs[0].w[i] = 32'(i + 1);
      vecs[1].w[i] = 32'hA5A5_0000 | 32'(i);
      vecs[2].w[i] = $urandom;
      vecs[3].w[i] = (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h8000_0001;
    end
    vecs[1].w[2] = SYNC_WORD;
    vecs[1].w[6] = SYNC_WORD;
    vecs[0].name = "count";
    vecs[1].name = "sync_payload";
    vecs[2].name = "random";
    vecs[3].name = "edges";

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge lvds_clk);
    check("rst_line", 64'(lvds_data_out), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_tx_busy", 64'(tx_busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    idle_watch("post_reset", 40);
    check("post_reset_state", 64'(dbg_state), 64'(ST_IDLE));

    // table-driven frames
    foreach (vecs[v]) begin
      fd0 = fd_q.size(); b0 = busy_q.size(); s0 = sync_q.size();
      for (int i = 0; i < WPF; i++) push_word(vecs[v].w[i]);
      frame_checks(vecs[v].name, fd0, b0, s0);
    end

    // threshold: seven words never start a frame
    for (int i = 0; i < WPF - 1; i++) push_word(32'hC0DE_0000 + 32'(i));
    idle_watch("threshold", 1000);
    fd0 = fd_q.size(); b0 = busy_q.size(); s0 = sync_q.size();
    push_word(32'hC0DE_00FF);
    frame_checks("threshold", fd0, b0, s0);
    if (sync_q.size() > s0)
      check("threshold_start_latency", 64'(sync_q[s0] - 31), 64'(push_cyc + 1));

    // back-to-back: sixteen words, two frames at minimum spacing
    fd0 = fd_q.size(); b0 = busy_q.size(); s0 = sync_q.size();
    for (int i = 0; i < 2 * WPF; i++) push_word(32'h1357_0001 + 32'(i << 4));
    check("b2b_s_ready_full", 64'(s_ready), 64'd0);
    frame_checks("b2b_f1", fd0, b0, s0);
    frame_checks("b2b_f2", fd0 + 1, b0 + 1, s0 + 1);
    if (sync_q.size() > s0 + 1) begin
      st1 = sync_q[s0] - 31;
      st2 = sync_q[s0 + 1] - 31;
      check("b2b_period", 64'(st2 - st1), 64'd321);
      zeros = 0;
      n = st2 - 1;
      while (n > st1 && line_hist[n] == 1'b0 && zeros < 200) begin
        zeros++;
        n--;
      end
      check("b2b_gap_zeros", 64'(zeros), 64'd33);
    end else begin
      check("b2b_second_sync", 64'd0, 64'd1);
    end

    // reset in the middle of payload word 4
    fd0 = fd_q.size(); b0 = busy_q.size(); s0 = sync_q.size();
    for (int i = 0; i < WPF; i++) push_word(32'hDEAD_0000 + 32'(i));
    compare_rx("mid_reset_pre", 3);
    repeat (10) @(negedge lvds_clk);
    check("mid_reset_busy_before", 64'(tx_busy), 64'd1);
    @(posedge lvds_clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_line", 64'(lvds_data_out), 64'd0);
    check("mid_reset_fifo_count", 64'(u_dut.fifo_count), 64'd0);
    check("mid_reset_s_ready", 64'(s_ready), 64'd1);
    check("mid_reset_busy", 64'(tx_busy), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge lvds_clk);
    rst_n = 1'b1;
    rx_rd = rx_q.size();
    n = 0;
    while (dbg_state != ST_IDLE && n < 100) begin
      @(negedge lvds_clk);
      n++;
    end
    check("mid_reset_gap_len", 64'(n), 64'd32);
    for (int i = 0; i < WPF - 1; i++) push_word(32'h0BAD_F000 + 32'(i));
    idle_watch("mid_reset_refill", 300);
    fd0 = fd_q.size(); b0 = busy_q.size(); s0 = sync_q.size();
    push_word(32'h0BAD_F0FF);
    frame_checks("mid_reset_after", fd0, b0, s0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lvds_frame_tx.md
# lvds_frame_tx

Serial LVDS frame transmitter, the far-end stage feeding the LVDS receive path over a single data lane. Buffers 32-bit payload words from a parallel valid/ready source and serializes them MSB-first on lvds_clk. Each frame is a 32-bit sync word 0x5346444B ("SFDK"), followed back-to-back by WORDS_PER_FRAME payload words, followed by an all-zero inter-frame gap. The bit format matches the receiver's hunt-then-count framing exactly.

## Interface
- SYNC_WORD, 32'h5346444B, frame delimiter, sent MSB first.
- WORDS_PER_FRAME, 8, payload words per frame; must match the receiver.
- FIFO_DEPTH, 16, input word buffer depth; power of 2, ≥ WORDS_PER_FRAME.
- GAP_BITS, 32, minimum zero bits in GAP state; must be ≥ 32.
- lvds_clk  in  1  bit clock; all logic is in this domain.
- rst_n  in  1  reset; asynchronous, active-low.
- s_data  in  32  payload word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  high when FIFO count < FIFO_DEPTH.
- lvds_data_out  out  1  serial line; driven directly from tx_sh[31], no logic after the flop.
- tx_busy  out  1  high in SYNC or DATA.
- frame_done  out  1  one-cycle pulse on entry to GAP.

## Operation
- Push on an edge where s_valid && s_ready. A push while full cannot occur because s_ready is low.
- Push and pop on the same edge: count is unchanged, both take effect.
- States and transitions:
  - GAP (reset state): tx_sh = 0. Counts gap_cnt 0..GAP_BITS-1. At GAP_BITS-1 → IDLE.
  - IDLE: line 0. When count ≥ WORDS_PER_FRAME → SYNC; tx_sh ← SYNC_WORD, bit_cnt ← 0.
  - SYNC: shift left, zero fill, each edge. At bit_cnt==31: tx_sh ← FIFO head, pop, word_cnt ← 0, → DATA.
  - DATA: shift each edge. At bit_cnt==31 with word_cnt < WORDS_PER_FRAME-1: load next head, pop, word_cnt+1.
  - DATA end: at bit_cnt==31 with word_cnt == WORDS_PER_FRAME-1: tx_sh ← 0, frame_done ← 1, gap_cnt ← 0, → GAP.
- A frame starts only when a full frame is buffered, so underrun mid-frame cannot occur.
- Payload words equal to SYNC_WORD are sent unmodified. The receiver ignores them while receiving, and its LSB-1 sync word cannot match a window ending in idle zeros.
- Counters:
  - bit_cnt 5 bits, wraps 31→0.
  - word_cnt 3 bits for the default WORDS_PER_FRAME; clog2 in general.
  - FIFO pointers are clog2(FIFO_DEPTH) bits and wrap naturally; count is clog2+1 bits.
- Reset values:
  - lvds_data_out = 0, tx_busy = 0, frame_done = 0.
  - s_ready = 1; FIFO emptied.
  - State GAP, all counters 0.
- Reset mid-frame aborts immediately and the line goes to 0 asynchronously. The partial frame is lost, and buffered words are discarded.

## Timing
- Frame length is 32 + 32·WORDS_PER_FRAME bit-times: 288 with defaults.
- Minimum frame-to-frame period is 32 + 32·WORDS_PER_FRAME + GAP_BITS + 1 (one cycle in IDLE): 321 cycles with defaults.
- Minimum zeros between frames is GAP_BITS + 1.
- Start latency: if the WORDS_PER_FRAME-th word is pushed at edge A while in IDLE, count updates at A, SYNC is entered at A+1, and the sync MSB appears on the line after A+1.
- Pop timing: word n pops at the edge that loads it into tx_sh. s_ready may rise in the cycle after that pop.
- frame_done is high for exactly the cycle following the edge that launched the last payload LSB's successor (0).
- tx_busy:
  - Rises in the cycle after the SYNC entry edge.
  - Falls in the cycle after the GAP entry edge.
  - Stays high for exactly 288 cycles with defaults.

## Structure
- Shared package lvds_link_pkg holds:
  - SYNC_WORD and WORDS_PER_FRAME (also imported by the receive side).
  - LVDS_WORD_W = 32.
  - State enum {ST_GAP, ST_IDLE, ST_SYNC, ST_DATA}.
- One sub-module, lvds_tx_fifo: a synchronous single-clock FIFO, FIFO_DEPTH × 32. Ports push/pop/din/dout (first-word show-ahead), count, full.
- The framer FSM, counters and shift register are in the top module.

## Test plan
- Reset: hold rst_n low, release → lvds_data_out=0, s_ready=1, tx_busy=0, no frame_done. Line stays 0 for ≥ 33 cycles with no push.
- Single frame: push 0x00000001..0x00000008 → line carries 0x5346444B then words 1..8 MSB-first, contiguous. frame_done asserts once, 288 cycles after tx_busy rises.
- Threshold: push 7 words → line stays 0 for 1000 cycles. Push the 8th at edge A → sync MSB launched at A+1.
- Back-to-back: push 16 words (FIFO full, s_ready low after the 16th) → two frames with sync starts 321 cycles apart. Between them, exactly 33 zero bits.
- Payload equal to 0x5346444B in word 3 and word 7, looped into a lvds_rx model → receiver stores all 8 words intact with no false resync.
- Reset mid-DATA at word 4 → line 0 immediately, FIFO count 0. After release, 32-cycle GAP, and no frame until 8 new words are pushed.
